wrr_scheduler: RTL and testbench

Programmable weighted round-robin scheduler that shares one output port between `QUEUE_QUANTITY` FIFOs. It holds a double-buffered arbitration table; each table entry is a (weight, queue) pair. A new table is written through a configuration port and swapped in only at a round boundary. The scheduler walks the table, skips empty or disabled entries, and issues one-hot pops to the FIFO bank under downstream back-pressure. It sits between the FIFO bank (`buf_empty` and pop inputs) and the output mux, which is driven by `selector`.

---
 rtl/wrr_scheduler_pkg.sv | 25 ++
 rtl/wrr_scheduler_if.sv | 47 ++++
 rtl/wrr_scheduler_tabla_arbitraje.sv | 57 +++++
 rtl/wrr_scheduler.sv | 120 ++++++++++++
 tb/tb_wrr_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// wrr_scheduler_pkg
// Shared definitions for the weighted round-robin scheduler:
//   - state_t : scheduler FSM encoding (IDLE=0, LOAD=1, RUN=2)
//   - clog2w  : width helper used to derive QW/TW/WW from the sizing params
//   - DEF_*   : default sizing shared by the interface and the top level
// ---------------------------------------------------------------------------
package wrr_scheduler_pkg;

    localparam int DEF_QUEUE_QUANTITY = 4;
    localparam int DEF_TABLE_SIZE     = 8;
    localparam int DEF_MAX_WEIGHT     = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Never returns 0 so a degenerate size of 1 still yields a legal vector.
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_scheduler_if.sv
// ---------------------------------------------------------------------------
// wrr_scheduler_if
// Bundles the configuration port, FIFO-bank status, downstream handshake
// and grant outputs of the scheduler.
//   master : environment side (drives enb, cfg_*, buf_empty, out_ready)
//   slave  : scheduler side   (drives pop, selector, selector_enb, entry,
//                              commit_pending, round_done)
// ---------------------------------------------------------------------------
interface wrr_scheduler_if
    import wrr_scheduler_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    parameter int TABLE_SIZE     = DEF_TABLE_SIZE,
    parameter int MAX_WEIGHT     = DEF_MAX_WEIGHT
);
    localparam int QW = clog2w(QUEUE_QUANTITY);
    localparam int TW = clog2w(TABLE_SIZE);
    localparam int WW = clog2w(MAX_WEIGHT);

    logic                      enb;
    logic                      cfg_wr;
    logic [TW-1:0]             cfg_addr;
    logic [WW-1:0]             cfg_peso;
    logic [QW-1:0]             cfg_sel;
    logic                      cfg_commit;
    logic [QUEUE_QUANTITY-1:0] buf_empty;
    logic                      out_ready;
    logic [QUEUE_QUANTITY-1:0] pop;
    logic [QW-1:0]             selector;
    logic                      selector_enb;
    logic [TW-1:0]             entry;
    logic                      commit_pending;
    logic                      round_done;

    modport master (
        output enb, cfg_wr, cfg_addr, cfg_peso, cfg_sel, cfg_commit,
               buf_empty, out_ready,
        input  pop, selector, selector_enb, entry, commit_pending, round_done
    );

    modport slave (
        input  enb, cfg_wr, cfg_addr, cfg_peso, cfg_sel, cfg_commit,
               buf_empty, out_ready,
        output pop, selector, selector_enb, entry, commit_pending, round_done
    );

endinterface

// File: rtl/wrr_scheduler_tabla_arbitraje.sv
// ---------------------------------------------------------------------------
// tabla_arbitraje
// Double-buffered arbitration table. Configuration writes land in the shadow
// bank; i_load copies the whole shadow bank into the active bank in one edge.
// Ports:
//   i_clk, i_rst             : clock, async active-high reset (clears both banks)
//   i_wr, i_addr, i_peso,
//   i_sel                    : shadow write port (one entry per cycle)
//   i_load                   : copy shadow -> active
//   o_pesos, o_selecciones   : active bank, flattened (entry k at slice k)
//   o_peso_sh0               : shadow weight of entry 0, i.e. the credit the
//                              active entry 0 will hold right after a load
// ---------------------------------------------------------------------------
module tabla_arbitraje
    import wrr_scheduler_pkg::*;
#(
    parameter int TABLE_SIZE = DEF_TABLE_SIZE,
    parameter int QW         = 2,
    parameter int WW         = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr,
    input  logic [clog2w(TABLE_SIZE)-1:0] i_addr,
    input  logic [WW-1:0]            i_peso,
    input  logic [QW-1:0]            i_sel,
    input  logic                     i_load,
    output logic [TABLE_SIZE*WW-1:0] o_pesos,
    output logic [TABLE_SIZE*QW-1:0] o_selecciones,
    output logic [WW-1:0]            o_peso_sh0
);
    logic [TABLE_SIZE-1:0][WW-1:0] r_peso_sh, r_peso_a;
    logic [TABLE_SIZE-1:0][QW-1:0] r_sel_sh,  r_sel_a;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_peso_sh <= '0;
            r_sel_sh  <= '0;
            r_peso_a  <= '0;
            r_sel_a   <= '0;
        end else begin
            if (i_wr) begin
                r_peso_sh[i_addr] <= i_peso;
                r_sel_sh[i_addr]  <= i_sel;
            end
            if (i_load) begin
                r_peso_a <= r_peso_sh;
                r_sel_a  <= r_sel_sh;
            end
        end
    end

    assign o_pesos       = r_peso_a;
    assign o_selecciones = r_sel_a;
    assign o_peso_sh0    = r_peso_sh[0];

endmodule

// File: rtl/wrr_scheduler.sv
// ---------------------------------------------------------------------------
// wrr_scheduler
// Programmable weighted round-robin scheduler sharing one output port among
// QUEUE_QUANTITY FIFOs. Walks the active table entry by entry; an entry with
// weight w grants its queue up to w times back to back, empty/disabled
// entries are skipped at one cycle each. A committed table is swapped in only
// at a round boundary (pointer wrap).
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : wrr_scheduler_if.slave (config port, buf_empty, out_ready,
//              pop/selector/selector_enb grant, entry, commit_pending,
//              round_done)
// ---------------------------------------------------------------------------
module wrr_scheduler
    import wrr_scheduler_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    parameter int TABLE_SIZE     = DEF_TABLE_SIZE,
    parameter int MAX_WEIGHT     = DEF_MAX_WEIGHT
) (
    input  logic           clk,
    input  logic           rst,
    wrr_scheduler_if.slave bus
);
    localparam int QW = clog2w(QUEUE_QUANTITY);
    localparam int TW = clog2w(TABLE_SIZE);
    localparam int WW = clog2w(MAX_WEIGHT);

    state_t                        r_state, w_state_nxt;
    logic [TW-1:0]                 r_ptr, w_ptr_inc;
    logic [WW-1:0]                 r_cred;
    logic                          r_commit_pending;
    logic                          r_round_done;
    logic [TABLE_SIZE-1:0][WW-1:0] w_pesos;
    logic [TABLE_SIZE-1:0][QW-1:0] w_sels;
    logic [WW-1:0]                 w_peso_sh0;
    logic [QW-1:0]                 w_sel_cur;
    logic                          w_wr_acc, w_commit_acc, w_load, w_run;
    logic                          w_elig, w_grant, w_adv, w_wrap;

    // Config port is locked while a swap is pending.
    assign w_wr_acc     = bus.cfg_wr     && !r_commit_pending;
    assign w_commit_acc = bus.cfg_commit && !r_commit_pending;

    tabla_arbitraje #(
        .TABLE_SIZE (TABLE_SIZE),
        .QW         (QW),
        .WW         (WW)
    ) u_tabla (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr          (w_wr_acc),
        .i_addr        (bus.cfg_addr),
        .i_peso        (bus.cfg_peso),
        .i_sel         (bus.cfg_sel),
        .i_load        (w_load),
        .o_pesos       (w_pesos),
        .o_selecciones (w_sels),
        .o_peso_sh0    (w_peso_sh0)
    );

    // enb=0 freezes everything, including a LOAD in progress.
    assign w_load    = bus.enb && (r_state == ST_LOAD);
    assign w_run     = bus.enb && (r_state == ST_RUN);
    assign w_sel_cur = w_sels[r_ptr];
    assign w_elig    = (w_pesos[r_ptr] != '0) && !bus.buf_empty[w_sel_cur];
    assign w_grant   = w_run && w_elig && bus.out_ready;
    // Ineligible entries forfeit their credit; the last credit moves on too.
    assign w_adv     = w_run && (!w_elig || (w_grant && (r_cred <= WW'(1))));
    assign w_wrap    = w_adv && (r_ptr == TW'(TABLE_SIZE - 1));
    assign w_ptr_inc = (r_ptr == TW'(TABLE_SIZE - 1)) ? '0 : r_ptr + TW'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // A commit accepted this very cycle already moves us on, so the
            // copy happens the next cycle and the first grant one after.
            ST_IDLE: if (bus.enb && (w_commit_acc || r_commit_pending)) w_state_nxt = ST_LOAD;
            ST_LOAD: if (bus.enb) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_wrap && r_commit_pending) w_state_nxt = ST_LOAD;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_ptr            <= '0;
            r_cred           <= '0;
            r_commit_pending <= 1'b0;
            r_round_done     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_round_done <= w_wrap;
            if (w_load)
                r_commit_pending <= 1'b0;
            else if (w_commit_acc)
                r_commit_pending <= 1'b1;
            // Active bank is written on this same edge, so entry 0's credit
            // comes from the shadow copy.
            if (w_load) begin
                r_ptr  <= '0;
                r_cred <= w_peso_sh0;
            end else if (w_adv) begin
                r_ptr  <= w_ptr_inc;
                r_cred <= w_pesos[w_ptr_inc];
            end else if (w_grant) begin
                r_cred <= r_cred - WW'(1);
            end
        end
    end

    assign bus.selector_enb   = w_grant;
    assign bus.selector       = w_grant ? w_sel_cur : '0;
    assign bus.pop            = w_grant ? (QUEUE_QUANTITY'(1) << w_sel_cur) : '0;
    assign bus.entry          = r_ptr;
    assign bus.commit_pending = r_commit_pending;
    assign bus.round_done     = r_round_done && bus.enb;

endmodule

// File: tb/tb_wrr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wrr_scheduler
// Directed bench for wrr_scheduler. Stimulus pushes the hand-computed grant
// schedule (cycle, queue) into a queue; a negedge monitor pops and compares
// every grant the DUT presents and reports grants that never came.
// ---------------------------------------------------------------------------
module tb_wrr_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wrr_scheduler_if #(.QUEUE_QUANTITY(4), .TABLE_SIZE(8), .MAX_WEIGHT(64)) bus ();

    wrr_scheduler #(.QUEUE_QUANTITY(4), .TABLE_SIZE(8), .MAX_WEIGHT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   pop2_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_chk++;
                n_err++;
                $display("FAIL missed_grant: got no grant, required sel %0d at cycle %0d",
                         exp_q[0].sel, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.selector_enb) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_grant: got sel %0d at cycle %0d, required none",
                             bus.selector, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("grant_sel", int'(bus.selector), mon_e.sel);
                    chk("grant_pop", int'(bus.pop), 1 << mon_e.sel);
                end
            end
            if (bus.pop[2]) pop2_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push(input int c, input int s);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        exp_q.push_back(e);
    endtask

    // Reset, then write all 8 shadow entries, one per cycle.
    task automatic load_table(input int wt[8], input int sl[8]);
        rst = 1'b1;
        bus.enb = 1'b1; bus.out_ready = 1'b1; bus.buf_empty = '0;
        bus.cfg_wr = 1'b0; bus.cfg_commit = 1'b0;
        bus.cfg_addr = '0; bus.cfg_peso = '0; bus.cfg_sel = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) begin
            bus.cfg_wr   = 1'b1;
            bus.cfg_addr = 3'(i);
            bus.cfg_peso = 6'(wt[i]);
            bus.cfg_sel  = 2'(sl[i]);
            tick(1);
        end
        bus.cfg_wr = 1'b0;
    endtask

    // Commit in cycle cc; returns in cycle cc+1 (the LOAD cycle).
    task automatic commit(output int cc);
        bus.cfg_commit = 1'b1;
        cc = cyc;
        tick(1);
        bus.cfg_commit = 1'b0;
    endtask

    int w_a[8] = '{1, 1, 1, 1, 1, 1, 1, 1};
    int s_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int w_w[8] = '{3, 1, 0, 0, 0, 0, 0, 0};
    int s_w[8] = '{2, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        int cc, r, p2base;

        // ---- reset state
        bus.enb = 1'b1; bus.out_ready = 1'b1; bus.buf_empty = '0;
        bus.cfg_wr = 1'b0; bus.cfg_commit = 1'b0;
        bus.cfg_addr = '0; bus.cfg_peso = '0; bus.cfg_sel = '0;
        tick(3);
        chk("rst_pop",            int'(bus.pop), 0);
        chk("rst_selector_enb",   int'(bus.selector_enb), 0);
        chk("rst_selector",       int'(bus.selector), 0);
        chk("rst_entry",          int'(bus.entry), 0);
        chk("rst_commit_pending", int'(bus.commit_pending), 0);
        chk("rst_round_done",     int'(bus.round_done), 0);

        // ---- reset and first load: weight 1, queues 0,1,2,3,0,1,2,3
        load_table(w_a, s_a);
        bus.cfg_commit = 1'b1;
        cc = cyc;
        #1;
        chk("p1_commit_cycle_no_grant", int'(bus.selector_enb), 0);
        tick(1);
        bus.cfg_commit = 1'b0;
        #1;
        chk("p1_load_no_grant", int'(bus.selector_enb), 0);
        chk("p1_load_pending",  int'(bus.commit_pending), 1);
        for (int i = 0; i < 8; i++) push(cc + 2 + i, i % 4);
        wait_cyc(cc + 2); #1;
        chk("p1_pending_cleared", int'(bus.commit_pending), 0);
        wait_cyc(cc + 9); #1;
        chk("p1_round_done_early", int'(bus.round_done), 0);
        wait_cyc(cc + 10); #1;
        chk("p1_round_done", int'(bus.round_done), 1);
        bus.out_ready = 1'b0;
        wait_cyc(cc + 12);
        chk("p1_sb_empty", exp_q.size(), 0);

        // ---- weighting: (3,q2),(1,q0): 2,2,2,0 then 6 skips
        load_table(w_w, s_w);
        commit(cc);
        r = cc + 2;
        for (int k = 0; k < 3; k++) begin
            push(r + 10*k,     2);
            push(r + 10*k + 1, 2);
            push(r + 10*k + 2, 2);
            push(r + 10*k + 3, 0);
        end
        wait_cyc(r + 10); #1;
        chk("p2_round_done", int'(bus.round_done), 1);
        wait_cyc(r + 30);
        bus.out_ready = 1'b0;
        wait_cyc(r + 32);
        chk("p2_sb_empty", exp_q.size(), 0);

        // ---- skip empty queue 2: q0 once per 8 cycles
        load_table(w_w, s_w);
        bus.buf_empty = 4'b0100;
        p2base = pop2_cnt;
        commit(cc);
        r = cc + 2;
        for (int k = 0; k < 3; k++) push(r + 8*k + 1, 0);
        wait_cyc(r + 8); #1;
        chk("p3_round_done", int'(bus.round_done), 1);
        wait_cyc(r + 24);
        bus.out_ready = 1'b0;
        wait_cyc(r + 26);
        chk("p3_pop2_never", pop2_cnt - p2base, 0);
        chk("p3_sb_empty", exp_q.size(), 0);

        // ---- back-pressure during entry0 with 2 credits left
        load_table(w_w, s_w);
        commit(cc);
        r = cc + 2;
        push(r, 2); push(r + 6, 2); push(r + 7, 2); push(r + 8, 0);
        wait_cyc(r + 1);
        bus.out_ready = 1'b0;
        wait_cyc(r + 3); #1;
        chk("p4_stall_no_grant", int'(bus.selector_enb), 0);
        chk("p4_stall_entry",    int'(bus.entry), 0);
        wait_cyc(r + 5); #1;
        chk("p4_stall_entry_end", int'(bus.entry), 0);
        wait_cyc(r + 6);
        bus.out_ready = 1'b1;
        wait_cyc(r + 9);
        bus.out_ready = 1'b0;
        #1;
        chk("p4_entry_after", int'(bus.entry), 2);
        wait_cyc(r + 11);
        chk("p4_sb_empty", exp_q.size(), 0);

        // ---- pending-commit rules
        load_table(w_a, s_a);
        commit(cc);
        r = cc + 2;
        for (int i = 0; i < 8; i++) push(r + i, i % 4);
        push(r + 9, 3);  push(r + 10, 3); push(r + 11, 1); push(r + 12, 2);
        push(r + 13, 3); push(r + 14, 0); push(r + 15, 1); push(r + 16, 2);
        push(r + 17, 3);
        wait_cyc(r + 1);
        bus.cfg_wr = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_peso = 6'd2; bus.cfg_sel = 2'd3;
        tick(1);
        bus.cfg_wr = 1'b0;
        bus.cfg_commit = 1'b1;
        tick(1);
        bus.cfg_commit = 1'b0;
        bus.cfg_wr = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_peso = 6'd5; bus.cfg_sel = 2'd1;
        #1;
        chk("p5_pending_set", int'(bus.commit_pending), 1);
        tick(1);
        bus.cfg_wr = 1'b0;
        wait_cyc(r + 8); #1;
        chk("p5_load_pending",  int'(bus.commit_pending), 1);
        chk("p5_load_no_grant", int'(bus.selector_enb), 0);
        wait_cyc(r + 9); #1;
        chk("p5_pending_cleared", int'(bus.commit_pending), 0);
        wait_cyc(r + 18);
        bus.out_ready = 1'b0;
        wait_cyc(r + 20);
        chk("p5_sb_empty", exp_q.size(), 0);

        // ---- async reset mid-grant with a commit pending
        load_table(w_a, s_a);
        commit(cc);
        r = cc + 2;
        push(r, 0); push(r + 1, 1);
        wait_cyc(r + 1);
        bus.cfg_commit = 1'b1;
        tick(1);
        bus.cfg_commit = 1'b0;
        #1;
        chk("p6_pre_grant",   int'(bus.selector_enb), 1);
        chk("p6_pre_pending", int'(bus.commit_pending), 1);
        #1 rst = 1'b1;
        #1;
        chk("p6_rst_pop",     int'(bus.pop), 0);
        chk("p6_rst_grant",   int'(bus.selector_enb), 0);
        chk("p6_rst_pending", int'(bus.commit_pending), 0);
        chk("p6_rst_entry",   int'(bus.entry), 0);
        #4 rst = 1'b0;
        tick(5);
        chk("p6_idle_no_grant", int'(bus.selector_enb), 0);
        chk("p6_idle_entry",    int'(bus.entry), 0);
        chk("p6_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

endmodule
